// File: rtl/pma_rule_scanner_pkg.sv
// -----------------------------------------------------------------------------
// pma_rule_scanner_pkg
//   Shared types for the sequential PMA rule scanner:
//     - cva6_cfg_t / cva6_cfg_empty : the slice of the core configuration that
//       carries the non-idempotent, execute and cached region tables.
//     - pma_scan_state_e            : scanner FSM states (IDLE, SCAN, RESP).
//     - pma_attr_t                  : the three PMA attribute flags.
//     - range_check()               : the region match rule.
//     - max3()                      : helper for the scan-length constant.
// -----------------------------------------------------------------------------
package pma_rule_scanner_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                        NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]        NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]        NonIdempotentLength;
    int unsigned                        NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]        ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]        ExecuteRegionLength;
    int unsigned                        NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]        CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]        CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } pma_scan_state_e;

  typedef struct packed {
    logic nonidempotent;
    logic executable;
    logic cacheable;
  } pma_attr_t;

  // The upper bound is formed in 65 bits so a region ending exactly at the top
  // of the address space does not wrap to zero. A zero length never matches.
  function automatic logic range_check(input logic [63:0] base,
                                       input logic [63:0] len,
                                       input logic [63:0] addr);
    logic [64:0] limit;
    limit = {1'b0, base} + {1'b0, len};
    return (addr >= base) && ({1'b0, addr} < limit);
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pma_rule_scanner_slot_cmp.sv
// -----------------------------------------------------------------------------
// pma_rule_slot_cmp
//   Combinationally evaluates RulesPerCycle consecutive rule slots starting at
//   idx_i for all three region categories. A slot only contributes when it is
//   below that category's configured rule count.
//   Ports:
//     idx_i  : first slot index of this group
//     addr_i : physical address under test
//     hit_o  : per-category OR of the matches in this group
// -----------------------------------------------------------------------------
module pma_rule_slot_cmp
  import pma_rule_scanner_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
  parameter int unsigned RulesPerCycle = 1,
  parameter int unsigned IdxW          = $clog2(NrMaxRules) + 1
) (
  input  logic [IdxW-1:0] idx_i,
  input  logic [63:0]     addr_i,
  output pma_attr_t       hit_o
);

  logic [IdxW-1:0] slot;
  logic [IdxW-2:0] sel;

  // NOTE: every signal written here gets a default before any conditional
  //       assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_o = '0;
    slot  = '0;
    sel   = '0;
    for (int unsigned k = 0; k < RulesPerCycle; k++) begin
      slot = idx_i + IdxW'(k);
      sel  = slot[IdxW-2:0];
      if (32'(slot) < CVA6Cfg.NrNonIdempotentRules)
        hit_o.nonidempotent = hit_o.nonidempotent |
          range_check(CVA6Cfg.NonIdempotentAddrBase[sel],
                      CVA6Cfg.NonIdempotentLength[sel], addr_i);
      if (32'(slot) < CVA6Cfg.NrExecuteRegionRules)
        hit_o.executable = hit_o.executable |
          range_check(CVA6Cfg.ExecuteRegionAddrBase[sel],
                      CVA6Cfg.ExecuteRegionLength[sel], addr_i);
      if (32'(slot) < CVA6Cfg.NrCachedRegionRules)
        hit_o.cacheable = hit_o.cacheable |
          range_check(CVA6Cfg.CachedRegionAddrBase[sel],
                      CVA6Cfg.CachedRegionLength[sel], addr_i);
    end
  end

endmodule

// File: rtl/pma_rule_scanner.sv
// -----------------------------------------------------------------------------
// pma_rule_scanner
//   Multi-cycle PMA attribute lookup. An address accepted on the request
//   channel is compared against the non-idempotent, execute and cached region
//   tables RulesPerCycle slots per cycle; the three attribute flags are then
//   returned on the response channel and held until accepted.
//   Ports:
//     clk_i, rst_ni          : clock, asynchronous active-low reset
//     flush_i                : abort lookup / drop pending response
//     req_valid_i/ready_o    : request handshake, req_addr_i = address
//     rsp_valid_o/ready_i    : response handshake
//     rsp_nonidempotent_o, rsp_executable_o, rsp_cacheable_o : attributes
//     busy_o                 : scanner not idle
//   Optional: PMA_SCANNER_LAST_RESULT_EN builds a one-entry cache of the last
//   scanned address so a repeat lookup skips the scan.
// -----------------------------------------------------------------------------
module pma_rule_scanner
  import pma_rule_scanner_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
  parameter int unsigned RulesPerCycle = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_addr_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_nonidempotent_o,
  output logic        rsp_executable_o,
  output logic        rsp_cacheable_o,
  output logic        busy_o
);

  localparam int unsigned IdxW  = $clog2(NrMaxRules) + 1;
  localparam int unsigned NMax  = max3(CVA6Cfg.NrNonIdempotentRules,
                                       CVA6Cfg.NrExecuteRegionRules,
                                       CVA6Cfg.NrCachedRegionRules);
  localparam int unsigned Steps = (NMax + RulesPerCycle - 1) / RulesPerCycle;
  localparam logic [IdxW-1:0] LastIdx =
    IdxW'((Steps > 0) ? (Steps - 1) * RulesPerCycle : 0);
  localparam logic [IdxW-1:0] IdxStep = IdxW'(RulesPerCycle);

  // With no execute rules every address is executable, so that accumulator
  // starts at 1 and nothing can clear it.
  localparam pma_attr_t AccInit = '{
    nonidempotent: 1'b0,
    executable:    (CVA6Cfg.NrExecuteRegionRules == 0),
    cacheable:     1'b0
  };

  pma_scan_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [63:0]     addr_q, addr_d;
  pma_attr_t       acc_q, acc_d;
  pma_attr_t       slot_hit;

  pma_rule_slot_cmp #(
    .CVA6Cfg       (CVA6Cfg),
    .RulesPerCycle (RulesPerCycle),
    .IdxW          (IdxW)
  ) u_slot_cmp (
    .idx_i  (idx_q),
    .addr_i (addr_q),
    .hit_o  (slot_hit)
  );

`ifdef PMA_SCANNER_LAST_RESULT_EN
  logic        cache_valid_q;
  logic [63:0] cache_addr_q;
  pma_attr_t   cache_attr_q;
  logic        cache_load;
  logic        cache_hit;

  assign cache_hit = cache_valid_q && (cache_addr_q == req_addr_i);
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
`ifdef PMA_SCANNER_LAST_RESULT_EN
    cache_load  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // Flush wins over a simultaneous request, so ready drops with it.
        req_ready_o = ~flush_i;
        if (req_valid_i && !flush_i) begin
          addr_d  = req_addr_i;
          idx_d   = '0;
          acc_d   = AccInit;
          state_d = (Steps > 0) ? SCAN : RESP;
`ifdef PMA_SCANNER_LAST_RESULT_EN
          if (cache_hit) begin
            acc_d   = cache_attr_q;
            state_d = RESP;
          end
`endif
        end
      end
      SCAN: begin
        acc_d.nonidempotent = acc_q.nonidempotent | slot_hit.nonidempotent;
        acc_d.executable    = acc_q.executable    | slot_hit.executable;
        acc_d.cacheable     = acc_q.cacheable     | slot_hit.cacheable;
        idx_d               = idx_q + IdxStep;
        if (flush_i) begin
          state_d = IDLE;
        end else if (idx_q == LastIdx) begin
          state_d = RESP;
`ifdef PMA_SCANNER_LAST_RESULT_EN
          cache_load = 1'b1;
`endif
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        // A handshake coinciding with flush is simply consumed.
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  //       the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
    end
  end

`ifdef PMA_SCANNER_LAST_RESULT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_attr_q  <= '0;
    end else if (flush_i) begin
      cache_valid_q <= 1'b0;
    end else if (cache_load) begin
      cache_valid_q <= 1'b1;
      cache_addr_q  <= addr_q;
      cache_attr_q  <= acc_d;
    end
  end
`endif

  assign rsp_nonidempotent_o = acc_q.nonidempotent;
  assign rsp_executable_o    = acc_q.executable;
  assign rsp_cacheable_o     = acc_q.cacheable;
  assign busy_o              = (state_q != IDLE);

endmodule
